mem_access_unit: RTL and testbench



---
 rtl/mem_pkg.sv | 34 +++
 rtl/load_align.sv | 39 +++
 rtl/mem_access_unit.sv | 203 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_pkg                                                       |
// | Purpose  : Shared definitions for the MEM-stage access path: access size |
// |            encodings, the access FSM state type and an alignment helper. |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Size must already be normalised (encoding 3 folded onto SZ_WORD).
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    r = 1'b0;
    case (size)
      SZ_HALF: r = off[0];
      SZ_WORD: r = |off;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : load_align                                                    |
// | Purpose  : Combinational load-data aligner. Picks the addressed byte or  |
// |            halfword out of a little-endian 32-bit word and sign- or      |
// |            zero-extends it; words pass straight through.                 |
// | Ports    : word_i     [31:0] raw memory word                             |
// |            addr_i     [1:0]  byte offset within the word                 |
// |            size_i     [1:0]  SZ_BYTE / SZ_HALF / SZ_WORD (3 = word)      |
// |            unsigned_i        zero-extend instead of sign-extend          |
// |            data_o     [31:0] aligned, extended result                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'(word_i >> {addr_i, 3'b000});
    w_half = addr_i[1] ? word_i[31:16] : word_i[15:0];
    data_o = word_i;
    case (size_i)
      SZ_BYTE: data_o = unsigned_i ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: data_o = unsigned_i ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: data_o = word_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_access_unit                                               |
// | Purpose  : MEM-stage load/store controller. Issues a registered req/ack  |
// |            bus transaction, stalls the pipeline until it completes or    |
// |            times out, and returns aligned/extended load data.            |
// | Ports    : clk, rst_n              clock, async active-low reset         |
// |            memreadm, memwritem     load / store request (both = store)   |
// |            sizem, unsignedm        access size, zero-extend flag         |
// |            aluoutm, writedatam     byte address, right-aligned store data|
// |            rdm                     extended load data (DONE cycle)       |
// |            stall, misalign, buserr pipeline freeze, error pulses         |
// |            dmem_*                  data-memory bus (outputs registered)  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memreadm,
  input  logic        memwritem,
  input  logic [1:0]  sizem,
  input  logic        unsignedm,
  input  logic [31:0] aluoutm,
  input  logic [31:0] writedatam,
  output logic [31:0] rdm,
  output logic        stall,
  output logic        misalign,
  output logic        buserr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Load-extraction context captured at issue so DONE does not depend on
  // the MEM-stage inputs still being held.
  logic              ld_q, ld_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;

  logic              w_access;
  logic [1:0]        w_size;
  logic              w_misal;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load;

  // Request decode: byte enables and lane-replicated store data.
  always_comb begin
    w_access = memreadm | memwritem;
    w_size   = (sizem == 2'd3) ? SZ_WORD : sizem;
    w_misal  = is_misaligned(w_size, aluoutm[1:0]);
    case (w_size)
      SZ_BYTE: begin
        w_be    = 4'(4'b0001 << aluoutm[1:0]);
        w_wdata = {4{writedatam[7:0]}};
      end
      SZ_HALF: begin
        w_be    = aluoutm[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{writedatam[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = writedatam;
      end
    endcase
  end

  load_align u_load_align (
    .word_i     (rdata_q),
    .addr_i     (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (w_load)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    ld_d     = ld_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    stall    = 1'b0;
    misalign = 1'b0;
    buserr   = 1'b0;
    rdm      = 32'h0;

    case (state_q)
      IDLE: begin
        // Gating with rst_n keeps stall/misalign low while reset is held,
        // even if the pipeline still presents a request.
        if (w_access && rst_n) begin
          if (w_misal) begin
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = WAIT;
            req_d   = 1'b1;
            we_d    = memwritem;
            addr_d  = {aluoutm[31:2], 2'b00};
            be_d    = w_be;
            wdata_d = w_wdata;
            cnt_d   = '0;
            ld_d    = ~memwritem;
            size_d  = w_size;
            uns_d   = unsignedm;
            off_d   = aluoutm[1:0];
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == C_CNT_MAX) begin
          rdata_d = 32'h0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        buserr  = err_q;
        rdm     = ld_q ? w_load : 32'h0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_access_unit                                            |
// | Purpose  : Directed self-checking bench for mem_access_unit (TIMEOUT=4). |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memreadm, memwritem, unsignedm;
  logic [1:0]  sizem;
  logic [31:0] aluoutm, writedatam;
  logic [31:0] rdm;
  logic        stall, misalign, buserr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;

  int n_total = 0;
  int n_fail  = 0;

  // Values captured by the access task.
  logic [31:0] cap_rdm, cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we, cap_mis, cap_buserr, cap_done;
  int          cap_nstall, cap_nreq;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memreadm   (memreadm),
    .memwritem  (memwritem),
    .sizem      (sizem),
    .unsignedm  (unsignedm),
    .aluoutm    (aluoutm),
    .writedatam (writedatam),
    .rdm        (rdm),
    .stall      (stall),
    .misalign   (misalign),
    .buserr     (buserr),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge with the FSM in IDLE. Presents one MEM-stage
  // request, acks the first WAIT cycle when ack_en is set, and records what
  // the bus and pipeline outputs did until stall falls.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic un, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdat,
                        input bit ack_en);
    memreadm = rd; memwritem = wr; sizem = sz; unsignedm = un;
    aluoutm = addr; writedatam = wd;
    cap_nstall = 0; cap_nreq = 0; cap_done = 1'b0; cap_mis = 1'b0;
    cap_buserr = 1'b0; cap_rdm = 32'hxxxx_xxxx; cap_be = 4'h0; cap_we = 1'b0;
    cap_addr = 32'h0; cap_wdata = 32'h0;
    for (int c = 0; c < 40 && !cap_done; c++) begin
      @(negedge clk);
      if (c == 0) cap_mis = misalign;
      if (dmem_req) begin
        cap_nreq++;
        cap_be = dmem_be; cap_we = dmem_we; cap_addr = dmem_addr; cap_wdata = dmem_wdata;
        if (ack_en) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdat;
        end
      end
      if (stall) cap_nstall++;
      else begin
        cap_done = 1'b1;
        cap_rdm = rdm;
        cap_buserr = buserr;
      end
    end
    chk("access_completes", 32'(cap_done), 32'd1);
    @(posedge clk); #1;
    memreadm = 1'b0; memwritem = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    memreadm = 1'b0; memwritem = 1'b0; sizem = 2'd0; unsignedm = 1'b0;
    aluoutm = 32'h0; writedatam = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be", 32'(dmem_be), 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_rdm", rdm, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_buserr", 32'(buserr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // lw 0x100, ack in first WAIT cycle
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b1);
    chk("lw_nstall", 32'(cap_nstall), 32'd2);
    chk("lw_nreq", 32'(cap_nreq), 32'd1);
    chk("lw_be", 32'(cap_be), 32'hF);
    chk("lw_we", 32'(cap_we), 32'd0);
    chk("lw_addr", cap_addr, 32'h0000_0100);
    chk("lw_rdm", cap_rdm, 32'hDEAD_BEEF);
    chk("lw_buserr", 32'(cap_buserr), 32'd0);
    @(negedge clk);
    chk("lw_idle_rdm", rdm, 32'h0);
    chk("lw_idle_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;

    // lb / lbu at 0x103
    access(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1'b1);
    chk("lb_be", 32'(cap_be), 32'b1000);
    chk("lb_addr", cap_addr, 32'h0000_0100);
    chk("lb_rdm", cap_rdm, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1'b1);
    chk("lbu_rdm", cap_rdm, 32'h0000_0080);

    // lh upper half (sign), lhu lower half (zero)
    access(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 32'h80FF_0000, 1'b1);
    chk("lh_be", 32'(cap_be), 32'b1100);
    chk("lh_rdm", cap_rdm, 32'hFFFF_80FF);
    access(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0000, 32'h0, 32'h1234_F00D, 1'b1);
    chk("lhu_be", 32'(cap_be), 32'b0011);
    chk("lhu_rdm", cap_rdm, 32'h0000_F00D);

    // size 3 behaves as word
    access(1'b1, 1'b0, 2'd3, 1'b1, 32'h0000_0104, 32'h0, 32'h0123_4567, 1'b1);
    chk("sz3_be", 32'(cap_be), 32'hF);
    chk("sz3_rdm", cap_rdm, 32'h0123_4567);

    // sh 0x202
    access(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 1'b1);
    chk("sh_we", 32'(cap_we), 32'd1);
    chk("sh_be", 32'(cap_be), 32'b1100);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_addr", cap_addr, 32'h0000_0200);
    chk("sh_rdm", cap_rdm, 32'h0);

    // sb 0x001
    access(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_0055, 32'h0, 1'b1);
    chk("sb_be", 32'(cap_be), 32'b0010);
    chk("sb_wdata", cap_wdata, 32'h5555_5555);

    // read+write together is a store
    access(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'hA5A5_0F0F, 32'hFFFF_FFFF, 1'b1);
    chk("rw_we", 32'(cap_we), 32'd1);
    chk("rw_wdata", cap_wdata, 32'hA5A5_0F0F);
    chk("rw_rdm", cap_rdm, 32'h0);

    // misaligned lw and sh
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 1'b1);
    chk("mis_lw_pulse", 32'(cap_mis), 32'd1);
    chk("mis_lw_nreq", 32'(cap_nreq), 32'd0);
    chk("mis_lw_nstall", 32'(cap_nstall), 32'd0);
    chk("mis_lw_rdm", cap_rdm, 32'h0);
    access(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0201, 32'h1111_2222, 32'h0, 1'b1);
    chk("mis_sh_pulse", 32'(cap_mis), 32'd1);
    chk("mis_sh_nreq", 32'(cap_nreq), 32'd0);
    @(negedge clk);
    chk("mis_after_pulse", 32'(misalign), 32'd0);
    chk("mis_after_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;

    // ack while idle is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("idle_ack_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("idle_ack_req", 32'(dmem_req), 32'd0);
    chk("idle_ack_rdm", rdm, 32'h0);
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;

    // timeout: no ack
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 1'b0);
    chk("tmo_nreq", 32'(cap_nreq), 32'd4);
    chk("tmo_nstall", 32'(cap_nstall), 32'd5);
    chk("tmo_buserr", 32'(cap_buserr), 32'd1);
    chk("tmo_rdm", cap_rdm, 32'h0);
    @(negedge clk);
    chk("tmo_after_buserr", 32'(buserr), 32'd0);
    chk("tmo_after_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;

    // reset during WAIT
    memreadm = 1'b1; memwritem = 1'b0; sizem = 2'd2; unsignedm = 1'b0; aluoutm = 32'h0000_0500;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_req_before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_req", 32'(dmem_req), 32'd0);
    chk("rstw_stall", 32'(stall), 32'd0);
    memreadm = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, 1'b1);
    chk("post_rst_nstall", 32'(cap_nstall), 32'd2);
    chk("post_rst_rdm", cap_rdm, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
`default_nettype wire
